// File: rtl/md_pkg.sv
// md_pkg: shared constants, state encoding and request payload for the
// M-extension issue controller.
package md_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned F7_W  = 7;
   localparam int unsigned ST_W  = 3;

   localparam logic [6:0]      OPC_OP    = 7'b0110011;
   localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

   localparam int unsigned TIMEOUT_CYC_DEF = 80;

   localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [ST_W-1:0] ST_ISSUE = 3'd1;
   localparam logic [ST_W-1:0] ST_WAIT  = 3'd2;
   localparam logic [ST_W-1:0] ST_WB    = 3'd3;
   localparam logic [ST_W-1:0] ST_DRAIN = 3'd4;

   // Operands and destination latched at issue time
   typedef struct packed {
      logic [XLEN-1:0]  a;
      logic [XLEN-1:0]  b;
      logic [F3_W-1:0]  funct3;
      logic [REG_W-1:0] rd;
   } md_req_t;

endpackage

// File: rtl/md_decode.sv
// md_decode: combinational M-op detector.
//   instr  : 32-bit instruction word
//   is_mop : OP opcode with MULDIV funct7
//   rd     : destination register field
//   funct3 : M-op selector field
module md_decode
   import md_pkg::*;
(
   input  logic [XLEN-1:0]  instr,
   output logic             is_mop,
   output logic [REG_W-1:0] rd,
   output logic [F3_W-1:0]  funct3
);

   // Source register fields are not needed here; operand values arrive separately
   logic unused_rs_fields;

   assign is_mop           = (instr[6:0] == OPC_OP) && (instr[31:25] == F7_MULDIV);
   assign rd               = instr[11:7];
   assign funct3           = instr[14:12];
   assign unused_rs_fields = ^instr[24:15];

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues decode-stage M-ops to a multi-cycle M-unit, stalls the
// front end while an op is outstanding, and hands the result to writeback.
//   clk, rst (async, active-low)
//   id_*       : decode-stage instruction and operands; id_stall freezes upstream
//   flush      : pipeline flush (outstanding unit request is drained, not withdrawn)
//   md_*       : M-unit request (start/operands/funct) and response (result/ready/busy/dbz)
//   wb_*       : writeback valid/ready handshake with rd and data
//   dbz_sticky : divide-by-zero seen, cleared by dbz_clr
//   timeout_err: watchdog expired waiting on the M-unit (sticky until reset)
module md_issue_ctrl
   import md_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_instr,
   input  logic [XLEN-1:0]  id_rs1_val,
   input  logic [XLEN-1:0]  id_rs2_val,
   input  logic             flush,
   output logic             id_stall,
   output logic             md_start,
   output logic             md_isMulDiv,
   output logic [XLEN-1:0]  md_A,
   output logic [XLEN-1:0]  md_B,
   output logic [F3_W-1:0]  md_funct3,
   output logic [F7_W-1:0]  md_funct7,
   input  logic [XLEN-1:0]  md_result,
   input  logic             md_ready,
   input  logic             md_busy,
   input  logic             md_div_by_zero,
   output logic             wb_valid,
   output logic [REG_W-1:0] wb_rd,
   output logic [XLEN-1:0]  wb_data,
   input  logic             wb_ready,
   output logic             dbz_sticky,
   output logic             timeout_err,
   input  logic             dbz_clr
);

   localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

   logic             dec_is_mop;
   logic [REG_W-1:0] dec_rd;
   logic [F3_W-1:0]  dec_funct3;

   logic [ST_W-1:0]  state_q;
   logic [ST_W-1:0]  state_d;
   md_req_t          req_q;
   logic [WD_W-1:0]  wd_q;

   logic             mop_req;
   logic             accept;
   logic             capture;
   logic             timeout;
   logic             wd_expired;

   md_decode u_decode (
      .instr  (id_instr),
      .is_mop (dec_is_mop),
      .rd     (dec_rd),
      .funct3 (dec_funct3)
   );

   assign mop_req    = id_valid && dec_is_mop && !flush;
   assign wd_expired = (wd_q == WD_LAST);

   // Stall must rise in the accept cycle itself, so it is combinational; held low in reset
   assign id_stall = rst && ((state_q != ST_IDLE) || mop_req);

   assign md_A      = req_q.a;
   assign md_B      = req_q.b;
   assign md_funct3 = req_q.funct3;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control decode
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      capture = 1'b0;
      timeout = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A still-busy unit (e.g. after a watchdog abort) holds the op in decode
            if (mop_req && !md_busy) begin
               accept  = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = flush ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            // Result arriving with a flush is already consumed, so skip DRAIN
            if (md_ready) begin
               capture = !flush && (req_q.rd != '0);
               state_d = capture ? ST_WB : ST_IDLE;
            end else if (wd_expired) begin
               timeout = 1'b1;
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_WB: begin
            if (flush || wb_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (md_ready) begin
               state_d = ST_IDLE;
            end else if (wd_expired) begin
               timeout = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered request, writeback, watchdog and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_q       <= '0;
         md_start    <= 1'b0;
         md_isMulDiv <= 1'b0;
         md_funct7   <= '0;
         wb_valid    <= 1'b0;
         wb_rd       <= '0;
         wb_data     <= '0;
         wd_q        <= '0;
         dbz_sticky  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         md_start    <= (state_d == ST_ISSUE);
         md_isMulDiv <= (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
         wb_valid    <= (state_d == ST_WB);

         if (accept) begin
            req_q     <= '{a: id_rs1_val, b: id_rs2_val, funct3: dec_funct3, rd: dec_rd};
            md_funct7 <= F7_MULDIV;
         end

         if (capture) begin
            wb_data <= md_result;
            wb_rd   <= req_q.rd;
         end

         if (state_q == ST_ISSUE) begin
            wd_q <= '0;
         end else if ((state_q == ST_WAIT) || (state_q == ST_DRAIN)) begin
            wd_q <= wd_q + WD_W'(1);
         end

         if (timeout) begin
            timeout_err <= 1'b1;
         end

         // Set has priority over a same-cycle clear
         if ((state_q == ST_WAIT) && md_div_by_zero) begin
            dbz_sticky <= 1'b1;
         end else if (dbz_clr) begin
            dbz_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_md_issue_ctrl.sv
`timescale 1ns/1ps
module tb_md_issue_ctrl;
   import md_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid, flush, wb_ready, dbz_clr;
   logic [31:0] id_instr, id_rs1_val, id_rs2_val;
   logic        id_stall, md_start, md_isMulDiv, wb_valid, dbz_sticky, timeout_err;
   logic [31:0] md_A, md_B, wb_data;
   logic [2:0]  md_funct3;
   logic [6:0]  md_funct7;
   logic [4:0]  wb_rd;
   logic [31:0] md_result;
   logic        md_ready, md_busy, md_div_by_zero;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;
   wb_exp_t sb_q[$];

   md_issue_ctrl #(.TIMEOUT_CYC(80)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_instr(id_instr), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
      .flush(flush), .id_stall(id_stall),
      .md_start(md_start), .md_isMulDiv(md_isMulDiv), .md_A(md_A), .md_B(md_B),
      .md_funct3(md_funct3), .md_funct7(md_funct7),
      .md_result(md_result), .md_ready(md_ready), .md_busy(md_busy), .md_div_by_zero(md_div_by_zero),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
      .dbz_sticky(dbz_sticky), .timeout_err(timeout_err), .dbz_clr(dbz_clr)
   );

   always #5 clk = ~clk;

   // Behavioural M-unit with programmable latency, stub mode and spurious ready
   int unsigned unit_lat   = 3;
   logic        unit_stub  = 1'b0;
   logic        spur_ready = 1'b0;
   logic        u_ready, u_busy, u_dbz, u_pdbz;
   logic [31:0] u_res, u_pend;
   int unsigned u_cnt;

   function automatic logic [31:0] m_calc(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic signed [31:0] da, db;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      da = a;
      db = b;
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0];  end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return (b == 0) ? 32'hFFFF_FFFF : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(da / db));
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: return (b == 0) ? a : ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(da % db));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         u_ready <= 1'b0; u_busy <= 1'b0; u_dbz <= 1'b0; u_pdbz <= 1'b0;
         u_res <= '0; u_pend <= '0; u_cnt <= 0;
      end else begin
         u_ready <= 1'b0;
         u_dbz   <= 1'b0;
         if (md_start && !unit_stub) begin
            u_busy <= 1'b1;
            u_cnt  <= unit_lat;
            u_pend <= m_calc(md_funct3, md_A, md_B);
            u_pdbz <= md_funct3[2] && (md_B == 32'd0);
         end else if (u_busy) begin
            if (u_cnt == 1) begin
               u_ready <= 1'b1;
               u_busy  <= 1'b0;
               u_res   <= u_pend;
               u_dbz   <= u_pdbz;
            end
            u_cnt <= u_cnt - 1;
         end
      end
   end

   assign md_ready       = u_ready | spur_ready;
   assign md_busy        = u_busy;
   assign md_result      = u_res;
   assign md_div_by_zero = u_dbz;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, OPC_OP};
   endfunction

   // Issue one M-op at the current negedge and follow it to completion
   task automatic run_op(input string tag, input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data, input int hold,
                         input logic flush_wb);
      int      cyc;
      int      starts;
      logic    saw_wb;
      logic [4:0] rd;
      wb_exp_t e;
      rd = instr[11:7];
      if (rd != 5'd0) sb_q.push_back('{rd: rd, data: exp_data});
      id_valid = 1'b1; id_instr = instr; id_rs1_val = a; id_rs2_val = b;
      #1 chk({tag, "_stall_accept"}, 32'(id_stall), 32'd1);
      @(negedge clk);
      id_valid = 1'b0; id_instr = '0;
      chk({tag, "_start"},  32'(md_start), 32'd1);
      chk({tag, "_md_A"},   md_A, a);
      chk({tag, "_md_B"},   md_B, b);
      chk({tag, "_funct3"}, 32'(md_funct3), 32'(instr[14:12]));
      chk({tag, "_funct7"}, 32'(md_funct7), 32'h1);
      chk({tag, "_ismd"},   32'(md_isMulDiv), 32'd1);
      starts = 0; cyc = 0; saw_wb = 1'b0;
      while (cyc < 200) begin
         if (md_start) starts++;
         if (wb_valid) begin saw_wb = 1'b1; dbz_clr = 1'b0; break; end
         if (!id_stall) break;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_start_count"}, 32'(starts), 32'd1);
      if (rd != 5'd0) begin
         chk({tag, "_wb_valid"}, 32'(saw_wb), 32'd1);
         chk({tag, "_latency"},  32'(cyc), 32'(unit_lat + 2));
         chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_wb_rd"},   32'(wb_rd), 32'(e.rd));
            chk({tag, "_wb_data"}, wb_data, e.data);
            repeat (hold) begin
               @(negedge clk);
               chk({tag, "_hold_valid"}, 32'(wb_valid), 32'd1);
               chk({tag, "_hold_data"},  wb_data, e.data);
               chk({tag, "_hold_rd"},    32'(wb_rd), 32'(e.rd));
            end
         end
         if (flush_wb) flush = 1'b1; else wb_ready = 1'b1;
         @(negedge clk);
         flush = 1'b0; wb_ready = 1'b0;
         chk({tag, "_wb_drop"}, 32'(wb_valid), 32'd0);
         chk({tag, "_release"}, 32'(id_stall), 32'd0);
      end else begin
         chk({tag, "_no_wb"},   32'(saw_wb), 32'd0);
         chk({tag, "_release"}, 32'(id_stall), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: still running at %0t, required to finish earlier", $time);
      $fatal(1);
   end

   initial begin
      int   cyc;
      logic saw;
      id_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0; dbz_clr = 1'b0;
      id_instr = '0; id_rs1_val = '0; id_rs2_val = '0;
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Reset: everything low, even with an M-op presented
      id_valid = 1'b1; id_instr = mk(F7_MULDIV, 3'd0, 5'd5); id_rs1_val = 32'h1234; id_rs2_val = 32'h5678;
      #1;
      chk("rst_id_stall", 32'(id_stall), 32'd0);
      chk("rst_md_start", 32'(md_start), 32'd0);
      chk("rst_ismd",     32'(md_isMulDiv), 32'd0);
      chk("rst_md_A",     md_A, 32'd0);
      chk("rst_md_B",     md_B, 32'd0);
      chk("rst_funct3",   32'(md_funct3), 32'd0);
      chk("rst_funct7",   32'(md_funct7), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_rd",    32'(wb_rd), 32'd0);
      chk("rst_wb_data",  wb_data, 32'd0);
      chk("rst_dbz",      32'(dbz_sticky), 32'd0);
      chk("rst_timeout",  32'(timeout_err), 32'd0);
      id_valid = 1'b0; id_instr = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Non-M-op (ADD) passes without stall or start
      id_valid = 1'b1; id_instr = mk(7'b0, 3'd0, 5'd4);
      #1 chk("add_no_stall", 32'(id_stall), 32'd0);
      @(negedge clk);
      chk("add_no_start", 32'(md_start), 32'd0);
      id_valid = 1'b0; id_instr = '0;

      unit_lat = 3;
      run_op("mul",  mk(F7_MULDIV, 3'd0, 5'd5), 32'd6, 32'd7, 32'd42, 0, 1'b0);
      unit_lat = 1;
      run_op("mulh", mk(F7_MULDIV, 3'd1, 5'd6), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 5, 1'b0);
      unit_lat = 5;
      run_op("div",  mk(F7_MULDIV, 3'd4, 5'd7), 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 1'b0);
      run_op("rem",  mk(F7_MULDIV, 3'd6, 5'd8), 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 1'b1);
      chk("dbz_idle_low", 32'(dbz_sticky), 32'd0);

      unit_lat = 2;
      run_op("divu0", mk(F7_MULDIV, 3'd5, 5'd9), 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
      chk("dbz_set", 32'(dbz_sticky), 32'd1);
      dbz_clr = 1'b1;
      @(negedge clk);
      dbz_clr = 1'b0;
      chk("dbz_clr", 32'(dbz_sticky), 32'd0);

      // Clear held through the div-by-zero pulse: set must win
      dbz_clr = 1'b1;
      run_op("divu0_setwins", mk(F7_MULDIV, 3'd5, 5'd9), 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 1'b0);
      chk("dbz_set_wins", 32'(dbz_sticky), 32'd1);
      dbz_clr = 1'b1;
      @(negedge clk);
      dbz_clr = 1'b0;

      run_op("mul_rd0", mk(F7_MULDIV, 3'd0, 5'd0), 32'd3, 32'd4, 32'd12, 0, 1'b0);

      // Flush three cycles after issue of DIV: drain, no writeback
      unit_lat = 8;
      id_valid = 1'b1; id_instr = mk(F7_MULDIV, 3'd4, 5'd10); id_rs1_val = 32'd100; id_rs2_val = 32'd7;
      @(negedge clk);
      id_valid = 1'b0; id_instr = '0;
      chk("flush_start", 32'(md_start), 32'd1);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_drain_stall", 32'(id_stall), 32'd1);
      chk("flush_drain_ismd",  32'(md_isMulDiv), 32'd1);
      cyc = 4; saw = 1'b0;
      while (id_stall && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (wb_valid) saw = 1'b1;
      end
      chk("flush_no_wb",    32'(saw), 32'd0);
      chk("flush_exit_cyc", 32'(cyc), 32'(unit_lat + 2));
      id_valid = 1'b1; id_instr = mk(7'b0, 3'd0, 5'd4);
      #1 chk("flush_add_no_stall", 32'(id_stall), 32'd0);
      @(negedge clk);
      chk("flush_add_no_start", 32'(md_start), 32'd0);
      id_valid = 1'b0; id_instr = '0;

      // Spurious ready in IDLE is ignored
      spur_ready = 1'b1;
      @(negedge clk);
      spur_ready = 1'b0;
      chk("spur_no_wb",    32'(wb_valid), 32'd0);
      chk("spur_no_stall", 32'(id_stall), 32'd0);

      // Stubbed unit: watchdog fires after 80 WAIT cycles
      unit_stub = 1'b1;
      id_valid = 1'b1; id_instr = mk(F7_MULDIV, 3'd0, 5'd3); id_rs1_val = 32'd2; id_rs2_val = 32'd3;
      @(negedge clk);
      id_valid = 1'b0; id_instr = '0;
      repeat (80) @(negedge clk);
      chk("wd_not_yet",       32'(timeout_err), 32'd0);
      chk("wd_still_stalled", 32'(id_stall), 32'd1);
      @(negedge clk);
      chk("wd_timeout_err", 32'(timeout_err), 32'd1);
      chk("wd_stall_drop",  32'(id_stall), 32'd0);
      chk("wd_no_wb",       32'(wb_valid), 32'd0);
      chk("wd_ismd_drop",   32'(md_isMulDiv), 32'd0);
      unit_stub = 1'b0;

      unit_lat = 4;
      run_op("mulhu", mk(F7_MULDIV, 3'd3, 5'd11), 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 1'b0);
      chk("wd_sticky", 32'(timeout_err), 32'd1);

      // Reset mid-operation abandons the op
      unit_lat = 10;
      id_valid = 1'b1; id_instr = mk(F7_MULDIV, 3'd0, 5'd12); id_rs1_val = 32'd9; id_rs2_val = 32'd9;
      @(negedge clk);
      id_valid = 1'b0; id_instr = '0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_stall",   32'(id_stall), 32'd0);
      chk("midrst_ismd",    32'(md_isMulDiv), 32'd0);
      chk("midrst_md_A",    md_A, 32'd0);
      chk("midrst_timeout", 32'(timeout_err), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      saw = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (wb_valid) saw = 1'b1;
      end
      chk("midrst_no_wb", 32'(saw), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
